// File: rtl/spi_controller.sv
// SPI mode-0 byte controller. One byte per start request, MSB first.
// Bytes chain under one chip select until a byte flagged last completes.
// Every output comes straight from a flop.
//
// Handshake: start is accepted on a rising edge of sys_clk where ready=1.
// tx_byte and last are captured on that edge. valid pulses for one cycle,
// in the same cycle that rx_byte takes its new value.
module spi_controller #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_GAP      = 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       last,
  output logic       ready,
  output logic [7:0] rx_byte,
  output logic       valid,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_tx,
  input  logic       spi_rx,
  output logic [2:0] dbg_state
);

  localparam int HPW = $clog2(HALF_PERIOD + 1);
  localparam int GPW = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHIFT_LO = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_WAIT     = 3'd3,
    S_HOLD     = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [HPW-1:0]   hp_q, hp_d;
  logic [GPW-1:0]   gap_q, gap_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       tx_sh_q, tx_sh_d;   // bits still to be sent after the one on spi_tx
  logic [6:0]       rx_sh_q, rx_sh_d;   // bits sampled so far in this byte
  logic             last_q, last_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             tx_q, tx_d;
  logic             rx_meta_q, rx_sync_q;

  // spi_rx is asynchronous; two flops before it is used. The data is stable
  // for a whole SCLK high phase, so the added latency is harmless.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
    end else begin
      rx_meta_q <= spi_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hp_q      <= '0;
      gap_q     <= '0;
      bit_q     <= 3'd0;
      tx_sh_q   <= 7'd0;
      rx_sh_q   <= 7'd0;
      last_q    <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rx_byte_q <= 8'h00;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      tx_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      rx_byte_q <= rx_byte_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      tx_q      <= tx_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    gap_d     = gap_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    last_d    = last_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    rx_byte_d = rx_byte_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    tx_d      = tx_q;

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (start) begin
          tx_sh_d = tx_byte[6:0];
          tx_d    = tx_byte[7];
          last_d  = last;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          hp_d    = '0;
          bit_d   = 3'd0;
          state_d = S_SHIFT_LO;
        end
      end
      S_SHIFT_LO: begin
        if (hp_q == HPW'(HALF_PERIOD - 1)) begin
          hp_d    = '0;
          sclk_d  = 1'b1;
          state_d = S_SHIFT_HI;
        end else begin
          hp_d = hp_q + HPW'(1);
        end
      end
      S_SHIFT_HI: begin
        if (hp_q == HPW'(HALF_PERIOD - 1)) begin
          hp_d    = '0;
          sclk_d  = 1'b0;
          bit_d   = bit_q + 3'd1;
          rx_sh_d = {rx_sh_q[5:0], rx_sync_q};
          if (bit_q == 3'd7) begin
            rx_byte_d = {rx_sh_q, rx_sync_q};
            valid_d   = 1'b1;
            if (last_q) begin
              state_d = S_HOLD;
            end else begin
              ready_d = 1'b1;
              state_d = S_WAIT;
            end
          end else begin
            tx_d    = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
            state_d = S_SHIFT_LO;
          end
        end else begin
          hp_d = hp_q + HPW'(1);
        end
      end
      S_HOLD: begin
        if (hp_q == HPW'(HALF_PERIOD - 1)) begin
          hp_d    = '0;
          cs_n_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          hp_d = hp_q + HPW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GPW'(CS_GAP - 1)) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GPW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign ready     = ready_q;
  assign valid     = valid_q;
  assign rx_byte   = rx_byte_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_sclk  = sclk_q;
  assign spi_tx    = tx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller at HALF_PERIOD=4, CS_GAP=2. spi_rx is either
// looped back from spi_tx or driven by a small mode-0 target model.
module tb_spi_controller;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_byte;
  logic       last;
  logic       ready;
  logic [7:0] rx_byte;
  logic       valid;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_tx;
  logic       spi_rx;
  logic [2:0] dbg_state;

  logic        loopback;
  logic [15:0] tgt_q;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  logic [7:0] exp_q[$];

  spi_controller #(.HALF_PERIOD(4), .CS_GAP(2)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .start    (start),
    .tx_byte  (tx_byte),
    .last     (last),
    .ready    (ready),
    .rx_byte  (rx_byte),
    .valid    (valid),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_tx   (spi_tx),
    .spi_rx   (spi_rx),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Mode-0 target: first bit ready when CS drops, next bit on each SCLK fall.
  always @(negedge spi_cs_n) tgt_q = 16'h3CC3;
  always @(negedge spi_sclk) tgt_q = {tgt_q[14:0], 1'b0};
  assign spi_rx = loopback ? spi_tx : tgt_q[15];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic valid_prev = 1'b0;
  always @(negedge sys_clk) begin
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
      check("valid_width", {31'd0, valid_prev}, 32'd0);
    end
    valid_prev = valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Issues one byte in the current cycle and follows it to its valid pulse.
  // Cycle k counts from acceptance (k=0); returns in the valid cycle.
  task automatic run_byte(input logic [7:0] tx, input logic lst, input logic [7:0] exp_rx,
                          input logic hold_start, input logic chg,
                          output logic [7:0] mosi, output int rise1, output int nrise,
                          output int vcyc, output logic ready_ok, output logic cs_ok);
    logic prev;
    int k;
    check("ready_at_accept", {31'd0, ready}, 32'd1);
    start = 1'b1; tx_byte = tx; last = lst;
    exp_q.push_back(exp_rx);
    mosi = 8'h00; rise1 = -1; nrise = 0; vcyc = -1; ready_ok = 1'b1; cs_ok = 1'b1;
    tick();
    k = 1;
    if (!hold_start) start = 1'b0;
    if (chg) begin tx_byte = ~tx; last = ~lst; end
    check("first_cycle_cs_n", {31'd0, spi_cs_n}, 32'd0);
    check("first_cycle_sclk", {31'd0, spi_sclk}, 32'd0);
    check("first_cycle_mosi", {31'd0, spi_tx}, {31'd0, tx[7]});
    prev = 1'b0;
    while (k < 200) begin
      if (spi_cs_n) cs_ok = 1'b0;
      if (valid) begin vcyc = k; break; end
      if (ready) ready_ok = 1'b0;
      if (spi_sclk && !prev) begin
        if (rise1 < 0) rise1 = k;
        nrise++;
        mosi = {mosi[6:0], spi_tx};
      end
      prev = spi_sclk;
      tick();
      k++;
    end
    if (vcyc < 0) check("valid_timeout", 32'd1, 32'd0);
  endtask

  // From the valid cycle (k=65) of a last byte: when CS rises and ready returns.
  task automatic wait_tail(output int cs_k, output int rdy_k);
    int k;
    k = 65; cs_k = -1; rdy_k = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      k++;
      if (spi_cs_n && cs_k < 0) cs_k = k;
      if (ready) begin rdy_k = k; break; end
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] mosi;
    int rise1, nrise, vcyc, cs_k, rdy_k, nv0;
    logic ready_ok, cs_ok, flag;

    vecs[0] = '{tx: 8'hA5, exp_mosi: 8'hA5, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'h00, exp_mosi: 8'h00, exp_rx: 8'h00};
    vecs[2] = '{tx: 8'hFF, exp_mosi: 8'hFF, exp_rx: 8'hFF};
    vecs[3] = '{tx: 8'h3C, exp_mosi: 8'h3C, exp_rx: 8'h3C};
    vecs[4] = '{tx: 8'h81, exp_mosi: 8'h81, exp_rx: 8'h81};

    loopback = 1'b1;
    reset = 1'b1; start = 1'b1; tx_byte = 8'hAA; last = 1'b1;

    // Reset state, with start held high to show reset wins.
    repeat (3) tick();
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'd0, spi_tx}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    start = 1'b0; reset = 1'b0;
    tick();

    // Loopback single bytes with full timing.
    for (int i = 0; i < 5; i++) begin
      run_byte(vecs[i].tx, 1'b1, vecs[i].exp_rx, 1'b0, 1'b0, mosi, rise1, nrise, vcyc, ready_ok, cs_ok);
      check("vec_mosi", {24'd0, mosi}, {24'd0, vecs[i].exp_mosi});
      check("vec_rises", nrise, 32'd8);
      check("vec_first_rise", rise1, 32'd5);
      check("vec_valid_cycle", vcyc, 32'd65);
      check("vec_ready_low", {31'd0, ready_ok}, 32'd1);
      check("vec_cs_low", {31'd0, cs_ok}, 32'd1);
      check("vec_hold_ready", {31'd0, ready}, 32'd0);
      wait_tail(cs_k, rdy_k);
      check("vec_cs_high_cycle", cs_k, 32'd69);
      check("vec_ready_cycle", rdy_k, 32'd71);
      tick();
    end

    // Target model, two chained bytes with start in the valid cycle.
    loopback = 1'b0;
    run_byte(8'h11, 1'b0, 8'h3C, 1'b0, 1'b0, mosi, rise1, nrise, vcyc, ready_ok, cs_ok);
    check("b2b_valid1", vcyc, 32'd65);
    check("b2b_wait_state", {29'd0, dbg_state}, {29'd0, ST_WAIT});
    check("b2b_cs1", {31'd0, cs_ok}, 32'd1);
    run_byte(8'h22, 1'b1, 8'hC3, 1'b0, 1'b0, mosi, rise1, nrise, vcyc, ready_ok, cs_ok);
    check("b2b_valid_gap", vcyc, 32'd65);
    check("b2b_cs2", {31'd0, cs_ok}, 32'd1);
    check("b2b_mosi2", {24'd0, mosi}, 32'h22);
    wait_tail(cs_k, rdy_k);
    check("b2b_ready_cycle", rdy_k, 32'd71);
    loopback = 1'b1;
    tick();

    // start held every cycle during a byte: one transfer only.
    nv0 = n_valid;
    run_byte(8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, mosi, rise1, nrise, vcyc, ready_ok, cs_ok);
    start = 1'b0;
    check("spam_valid_cycle", vcyc, 32'd65);
    check("spam_ready_low", {31'd0, ready_ok}, 32'd1);
    check("spam_mosi", {24'd0, mosi}, 32'h5A);
    wait_tail(cs_k, rdy_k);
    repeat (5) tick();
    check("spam_valid_count", n_valid - nv0, 32'd1);

    // Reset after the third SCLK rise aborts the byte.
    nv0 = n_valid;
    start = 1'b1; tx_byte = 8'h96; last = 1'b1;
    tick();
    start = 1'b0;
    nrise = 0;
    flag = 1'b0;
    for (int k = 0; k < 100 && nrise < 3; k++) begin
      if (spi_sclk && !flag) nrise++;
      flag = spi_sclk;
      if (nrise < 3) tick();
    end
    check("abort_rises_seen", nrise, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_rx_byte", {24'd0, rx_byte}, 32'd0);
    repeat (80) tick();
    check("abort_no_valid", n_valid - nv0, 32'd0);

    // tx_byte/last change after acceptance does not disturb the byte.
    run_byte(8'hFF, 1'b1, 8'hFF, 1'b0, 1'b1, mosi, rise1, nrise, vcyc, ready_ok, cs_ok);
    check("chg_mosi", {24'd0, mosi}, 32'hFF);
    check("chg_hold_state", {29'd0, dbg_state}, {29'd0, ST_HOLD});
    check("chg_ready", {31'd0, ready}, 32'd0);
    wait_tail(cs_k, rdy_k);
    check("chg_ready_cycle", rdy_k, 32'd71);
    tick();

    // last=0 then idle: controller parks in WAIT with CS low.
    run_byte(8'h42, 1'b0, 8'h42, 1'b0, 1'b0, mosi, rise1, nrise, vcyc, ready_ok, cs_ok);
    flag = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (dbg_state != ST_WAIT || spi_cs_n || spi_sclk || !ready) flag = 1'b0;
    end
    check("wait_park", {31'd0, flag}, 32'd1);
    check("wait_rx_byte", {24'd0, rx_byte}, 32'h42);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: sys_clk cycles per SCLK half-period; legal range 4..255.
REQ-002 SHALL have parameter CS_GAP, default 2: minimum sys_clk cycles spi_cs_n is held high between transactions; legal range 1..255.
REQ-003 SHALL have port sys_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request to transfer one byte; accepted only in a cycle where ready=1.
REQ-006 SHALL have port tx_byte  in  8  byte to send, MSB first; captured on acceptance.
REQ-007 SHALL have port last  in  1  final byte of the transaction; captured on acceptance.
REQ-008 SHALL have port ready  out  1  high when start will be accepted.
REQ-009 SHALL have port rx_byte  out  8  last byte received; holds its value until the next completed byte.
REQ-010 SHALL have port valid  out  1  one-cycle pulse marking that rx_byte was updated.
REQ-011 SHALL have port spi_cs_n  out  1  active-low target select.
REQ-012 SHALL have port spi_sclk  out  1  SPI mode 0 clock; idles low.
REQ-013 SHALL have port spi_tx  out  1  controller-to-target data (MOSI).
REQ-014 SHALL have port spi_rx  in  1  target-to-controller data (MISO); asynchronous to sys_clk.
REQ-015 SHALL drive every output from a flop; no combinational input-to-output path.

Function
REQ-016 SHALL implement the states IDLE, SHIFT_LO, SHIFT_HI, WAIT, HOLD and GAP.
REQ-017 IDLE: ready=1, spi_cs_n=1, spi_sclk=0; on start, SHALL go to SHIFT_LO.
REQ-018 On acceptance in cycle N, in cycle N+1 SHALL have spi_cs_n=0, spi_sclk=0, spi_tx=tx_byte[7] and ready=0.
REQ-019 SHIFT_LO SHALL last HALF_PERIOD cycles with spi_sclk=0, then SHALL raise spi_sclk and enter SHIFT_HI; the first rise occurs in cycle N+1+HALF_PERIOD.
REQ-020 SHIFT_HI SHALL last HALF_PERIOD cycles with spi_sclk=1.
REQ-021 At the end of SHIFT_HI, SHALL sample spi_rx into bit 0 of the receive shift register and drop spi_sclk in the same edge.
REQ-022 On each SCLK fall for bits 0..6, SHALL drive the next tx bit on spi_tx and return to SHIFT_LO.
REQ-023 spi_tx SHALL be stable across each entire SCLK low+high period.
REQ-024 SHALL use a 3-bit bit counter that wraps 7->0.
REQ-025 SHALL size the half-period counter at $clog2(HALF_PERIOD+1) bits.
REQ-026 On the 8th SCLK fall, SHALL in the same edge load rx_byte with the 8 sampled bits (first sampled = bit 7) and pulse valid for exactly 1 cycle.
REQ-027 On the 8th SCLK fall with last=0: SHALL enter WAIT with ready=1 (same cycle as valid) and spi_cs_n=0.
REQ-028 On the 8th SCLK fall with last=1: SHALL enter HOLD with ready=0.
REQ-029 WAIT: on start, SHALL behave as REQ-018 with spi_cs_n remaining low; start held in the valid cycle yields back-to-back bytes with no extra idle cycles.
REQ-030 HOLD SHALL keep spi_cs_n=0 and spi_sclk=0 for HALF_PERIOD cycles, then set spi_cs_n=1 and enter GAP.
REQ-031 GAP SHALL keep spi_cs_n=1 and ready=0 for CS_GAP cycles, then enter IDLE.
REQ-032 SHALL ignore start while ready=0; tx_byte and last changes after acceptance SHALL NOT affect the byte in flight.
REQ-033 A byte takes 16*HALF_PERIOD cycles from acceptance+1 to valid.

Reset
REQ-034 While reset=1 at a clock edge, the next cycle SHALL have state=IDLE, spi_cs_n=1, spi_sclk=0, spi_tx=0, ready=1, valid=0 and rx_byte=0x00.
REQ-035 Reset SHALL take priority over start in the same cycle.
REQ-036 Reset mid-byte SHALL abort the byte with no valid pulse; no CS_GAP is enforced after reset.

Verification
REQ-037 Loopback (spi_rx=spi_tx), HALF_PERIOD=4, start tx_byte=0xA5 last=1 at N -> MOSI 1,0,1,0,0,1,0,1; 8 SCLK rises, first at N+5; valid at N+65 with rx_byte=0xA5; spi_cs_n high at N+69; ready at N+71.
REQ-038 Mode-0 target model returning 0x3C then 0xC3, two bytes with start held in the valid cycle -> spi_cs_n low throughout; rx_byte 0x3C then 0xC3; second valid exactly 65 cycles after the first.
REQ-039 start pulsed every cycle during a byte -> exactly one byte transferred; ready=0 until valid.
REQ-040 reset asserted after the 3rd SCLK rise -> next cycle spi_cs_n=1, spi_sclk=0, ready=1; no valid pulse; rx_byte=0x00.
REQ-041 Change tx_byte from 0xFF to 0x00 one cycle after acceptance -> MOSI still shifts out 0xFF.
REQ-042 last=0 then idle with start=0 for 100 cycles -> remains in WAIT with spi_cs_n=0, spi_sclk=0, ready=1.
